// File: rtl/mem_lsu.sv
//------------------------------------------------------------------------------
// Module  : mem_lsu
// Brief   : MEM pipeline stage with req/ack load/store unit, alignment checks
//           and bus timeout.
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_lsu #(
  parameter int REG_ADDR_W = 5,
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic                  we_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [31:0]           mem_sdata_i,
  output logic                  stall_o,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_W-1:0]     dmem_addr_o,
  output logic [3:0]            dmem_be_o,
  output logic [31:0]           dmem_wdata_o,
  input  logic                  dmem_ack_i,
  input  logic [31:0]           dmem_rdata_i,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic                  we_o,
  output logic [31:0]           wdata_o,
  output logic                  adel_o,
  output logic                  ades_o,
  output logic                  buserr_o
);

  localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [3:0] c_OP_LB  = 4'd1;
  localparam logic [3:0] c_OP_LBU = 4'd2;
  localparam logic [3:0] c_OP_LH  = 4'd3;
  localparam logic [3:0] c_OP_LHU = 4'd4;
  localparam logic [3:0] c_OP_LW  = 4'd5;
  localparam logic [3:0] c_OP_SB  = 4'd6;
  localparam logic [3:0] c_OP_SH  = 4'd7;
  localparam logic [3:0] c_OP_SW  = 4'd8;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_REQ = 1'b1} state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [3:0]           r_op;
  logic [1:0]           r_k;
  logic                 r_we_lat;

  logic                 w_is_load, w_is_store, w_byte, w_half, w_word;
  logic                 w_misal, w_start, w_timeout;
  logic [1:0]           w_lane, w_rlane;
  logic                 w_hi_half, w_rhi_half;
  logic [3:0]           w_be;
  logic [31:0]          w_swdata, w_rshift, w_load;

  // Request decode on the incoming instruction
  always_comb begin
    w_is_load  = (mem_op_i >= c_OP_LB) && (mem_op_i <= c_OP_LW);
    w_is_store = (mem_op_i >= c_OP_SB) && (mem_op_i <= c_OP_SW);
    w_byte     = (mem_op_i == c_OP_LB) || (mem_op_i == c_OP_LBU) || (mem_op_i == c_OP_SB);
    w_half     = (mem_op_i == c_OP_LH) || (mem_op_i == c_OP_LHU) || (mem_op_i == c_OP_SH);
    w_word     = (mem_op_i == c_OP_LW) || (mem_op_i == c_OP_SW);
    w_misal    = (w_half && mem_addr_i[0]) || (w_word && (mem_addr_i[1:0] != 2'b00));
    w_start    = (r_state == S_IDLE) && valid_i && (w_is_load || w_is_store) && !w_misal;
    // 3-k is the bitwise complement for a 2-bit index
    w_lane     = (BIG_ENDIAN != 0) ? ~mem_addr_i[1:0] : mem_addr_i[1:0];
    w_hi_half  = (BIG_ENDIAN != 0) ? ~mem_addr_i[1] : mem_addr_i[1];
    w_be       = 4'hF;
    w_swdata   = mem_sdata_i;
    if (w_byte) begin
      w_be     = 4'b0001 << w_lane;
      w_swdata = {4{mem_sdata_i[7:0]}};
    end else if (w_half) begin
      w_be     = w_hi_half ? 4'b1100 : 4'b0011;
      w_swdata = {2{mem_sdata_i[15:0]}};
    end
  end

  // Load extraction from the latched op and address offset
  always_comb begin
    w_rlane    = (BIG_ENDIAN != 0) ? ~r_k : r_k;
    w_rhi_half = (BIG_ENDIAN != 0) ? ~r_k[1] : r_k[1];
    w_rshift   = dmem_rdata_i >> {w_rlane, 3'b000};
    case (r_op)
      c_OP_LB:  w_load = {{24{w_rshift[7]}}, w_rshift[7:0]};
      c_OP_LBU: w_load = {24'd0, w_rshift[7:0]};
      c_OP_LH:  w_load = w_rhi_half ? {{16{dmem_rdata_i[31]}}, dmem_rdata_i[31:16]}
                                    : {{16{dmem_rdata_i[15]}}, dmem_rdata_i[15:0]};
      c_OP_LHU: w_load = w_rhi_half ? {16'd0, dmem_rdata_i[31:16]} : {16'd0, dmem_rdata_i[15:0]};
      default:  w_load = dmem_rdata_i;
    endcase
  end

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_CNT_W'(TIMEOUT));

  always_comb begin
    w_state_nxt = r_state;
    stall_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_REQ;
          stall_o     = 1'b1;
        end
      end
      S_REQ: begin
        stall_o = !dmem_ack_i;
        if (dmem_ack_i || w_timeout) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_op         <= 4'd0;
      r_k          <= 2'd0;
      r_we_lat     <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= 4'd0;
      dmem_wdata_o <= 32'd0;
      valid_o      <= 1'b0;
      waddr_o      <= '0;
      we_o         <= 1'b0;
      wdata_o      <= 32'd0;
      adel_o       <= 1'b0;
      ades_o       <= 1'b0;
      buserr_o     <= 1'b0;
    end else if (r_state == S_IDLE) begin
      valid_o  <= 1'b0;
      we_o     <= 1'b0;
      adel_o   <= 1'b0;
      ades_o   <= 1'b0;
      buserr_o <= 1'b0;
      if (valid_i) begin
        waddr_o <= waddr_i;
        wdata_o <= wdata_i;
        if (w_start) begin
          r_we_lat     <= we_i;
          r_op         <= mem_op_i;
          r_k          <= mem_addr_i[1:0];
          r_cnt        <= c_CNT_W'(1);
          dmem_req_o   <= 1'b1;
          dmem_we_o    <= w_is_store;
          dmem_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
          dmem_be_o    <= w_be;
          dmem_wdata_o <= w_swdata;
        end else if (w_misal) begin
          valid_o <= 1'b1;
          adel_o  <= w_is_load;
          ades_o  <= w_is_store;
        end else begin
          valid_o <= 1'b1;
          we_o    <= we_i;
        end
      end
    end else begin
      if (dmem_ack_i) begin
        dmem_req_o <= 1'b0;
        valid_o    <= 1'b1;
        we_o       <= r_we_lat;
        r_cnt      <= '0;
        if (!dmem_we_o) wdata_o <= w_load;
      end else if (w_timeout) begin
        dmem_req_o <= 1'b0;
        valid_o    <= 1'b1;
        we_o       <= 1'b0;
        buserr_o   <= 1'b1;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_lsu
// Brief   : Directed vector bench for mem_lsu (BIG_ENDIAN=1, TIMEOUT=15).
// Rev     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic [4:0]  waddr_i = '0;
  logic        we_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [3:0]  mem_op_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] mem_sdata_i = '0;
  logic        stall_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        valid_o;
  logic [4:0]  waddr_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic        adel_o, ades_o, buserr_o;

  mem_lsu #(.REG_ADDR_W(5), .ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .waddr_i(waddr_i), .we_i(we_i),
    .wdata_i(wdata_i), .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i),
    .mem_sdata_i(mem_sdata_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_o(valid_o), .waddr_o(waddr_o), .we_o(we_o), .wdata_o(wdata_o),
    .adel_o(adel_o), .ades_o(ades_o), .buserr_o(buserr_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr, sdata, rdata, wdata;
    logic [4:0]  waddr;
    logic        we, mem, st;
    logic [3:0]  be;
    logic [31:0] daddr, dwd, wdo;
    logic        weo, adel, ades;
  } vec_t;

  vec_t vt[19];

  task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] wa, input logic we, input logic [31:0] wd);
    valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; mem_sdata_i = sd;
    waddr_i = wa; we_i = we; wdata_i = wd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive(v.op, v.addr, v.sdata, v.waddr, v.we, v.wdata);
    #1 chk($sformatf("v%0d stall", idx), stall_o, v.mem);
    tick();
    valid_i = 1'b0;
    chk($sformatf("v%0d req", idx), dmem_req_o, v.mem);
    if (v.mem) begin
      chk($sformatf("v%0d be", idx), dmem_be_o, v.be);
      chk($sformatf("v%0d daddr", idx), dmem_addr_o, v.daddr);
      chk($sformatf("v%0d dwe", idx), dmem_we_o, v.st);
      if (v.st) chk($sformatf("v%0d dwdata", idx), dmem_wdata_o, v.dwd);
      dmem_ack_i = 1'b1; dmem_rdata_i = v.rdata;
      #1 chk($sformatf("v%0d stall_ack", idx), stall_o, 1'b0);
      tick();
      dmem_ack_i = 1'b0; dmem_rdata_i = '0;
      chk($sformatf("v%0d req_drop", idx), dmem_req_o, 1'b0);
    end
    chk($sformatf("v%0d valid", idx), valid_o, 1'b1);
    chk($sformatf("v%0d waddr", idx), waddr_o, v.waddr);
    chk($sformatf("v%0d we", idx), we_o, v.weo);
    if (!(v.adel || v.ades)) chk($sformatf("v%0d wdata", idx), wdata_o, v.wdo);
    chk($sformatf("v%0d adel", idx), adel_o, v.adel);
    chk($sformatf("v%0d ades", idx), ades_o, v.ades);
    chk($sformatf("v%0d buserr", idx), buserr_o, 1'b0);
    tick();
    chk($sformatf("v%0d valid_clr", idx), valid_o, 1'b0);
  endtask

  initial begin
    //         op    addr          sdata         rdata         wdata         wa  we mem st be       daddr         dwd           wdo           weo adel ades
    vt[0]  = '{4'd0, 32'h0000_0000, 32'h0,       32'h0,        32'h0000_1234, 5'd3, 1, 0, 0, 4'b0000, 32'h0,       32'h0,        32'h0000_1234, 1, 0, 0};
    vt[1]  = '{4'd12,32'h0000_1000, 32'h0,       32'h0,        32'h0000_DEAD, 5'd7, 1, 0, 0, 4'b0000, 32'h0,       32'h0,        32'h0000_DEAD, 1, 0, 0};
    vt[2]  = '{4'd0, 32'h0000_0000, 32'h0,       32'h0,        32'h0000_0077, 5'd9, 0, 0, 0, 4'b0000, 32'h0,       32'h0,        32'h0000_0077, 0, 0, 0};
    vt[3]  = '{4'd1, 32'h0000_1001, 32'h0,       32'h1180_3344, 32'h0,        5'd4, 1, 1, 0, 4'b0100, 32'h0000_1000, 32'h0,      32'hFFFF_FF80, 1, 0, 0};
    vt[4]  = '{4'd2, 32'h0000_1001, 32'h0,       32'h1180_3344, 32'h0,        5'd4, 1, 1, 0, 4'b0100, 32'h0000_1000, 32'h0,      32'h0000_0080, 1, 0, 0};
    vt[5]  = '{4'd1, 32'h0000_1000, 32'h0,       32'h1180_3344, 32'h0,        5'd5, 1, 1, 0, 4'b1000, 32'h0000_1000, 32'h0,      32'h0000_0011, 1, 0, 0};
    vt[6]  = '{4'd1, 32'h0000_1003, 32'h0,       32'h0000_00FF, 32'h0,        5'd6, 1, 1, 0, 4'b0001, 32'h0000_1000, 32'h0,      32'hFFFF_FFFF, 1, 0, 0};
    vt[7]  = '{4'd3, 32'h0000_1002, 32'h0,       32'h1234_F00D, 32'h0,        5'd8, 1, 1, 0, 4'b0011, 32'h0000_1000, 32'h0,      32'hFFFF_F00D, 1, 0, 0};
    vt[8]  = '{4'd4, 32'h0000_1000, 32'h0,       32'h8765_0000, 32'h0,        5'd9, 1, 1, 0, 4'b1100, 32'h0000_1000, 32'h0,      32'h0000_8765, 1, 0, 0};
    vt[9]  = '{4'd3, 32'h0000_1000, 32'h0,       32'h7FFF_0000, 32'h0,        5'd10,1, 1, 0, 4'b1100, 32'h0000_1000, 32'h0,      32'h0000_7FFF, 1, 0, 0};
    vt[10] = '{4'd5, 32'h0000_1004, 32'h0,       32'hCAFE_BABE, 32'h0,        5'd11,1, 1, 0, 4'b1111, 32'h0000_1004, 32'h0,      32'hCAFE_BABE, 1, 0, 0};
    vt[11] = '{4'd7, 32'h0000_2002, 32'h0000_ABCD, 32'h0,      32'h0000_0055, 5'd0, 0, 1, 1, 4'b0011, 32'h0000_2000, 32'hABCD_ABCD, 32'h0000_0055, 0, 0, 0};
    vt[12] = '{4'd6, 32'h0000_2003, 32'h0000_01EF, 32'h0,      32'h0000_0066, 5'd0, 0, 1, 1, 4'b0001, 32'h0000_2000, 32'hEFEF_EFEF, 32'h0000_0066, 0, 0, 0};
    vt[13] = '{4'd6, 32'h0000_2000, 32'h0000_005A, 32'h0,      32'h0000_0067, 5'd0, 0, 1, 1, 4'b1000, 32'h0000_2000, 32'h5A5A_5A5A, 32'h0000_0067, 0, 0, 0};
    vt[14] = '{4'd8, 32'h0000_2004, 32'h0123_4567, 32'h0,      32'h0000_0088, 5'd12,1, 1, 1, 4'b1111, 32'h0000_2004, 32'h0123_4567, 32'h0000_0088, 1, 0, 0};
    vt[15] = '{4'd5, 32'h0000_0003, 32'h0,       32'h0,        32'h0000_0099, 5'd13,1, 0, 0, 4'b0000, 32'h0,       32'h0,        32'h0,         0, 1, 0};
    vt[16] = '{4'd8, 32'h0000_0002, 32'h0,       32'h0,        32'h0000_0099, 5'd14,1, 0, 0, 4'b0000, 32'h0,       32'h0,        32'h0,         0, 0, 1};
    vt[17] = '{4'd3, 32'h0000_0001, 32'h0,       32'h0,        32'h0000_0099, 5'd15,1, 0, 0, 4'b0000, 32'h0,       32'h0,        32'h0,         0, 1, 0};
    vt[18] = '{4'd7, 32'h0000_0005, 32'h0,       32'h0,        32'h0000_0099, 5'd16,0, 0, 0, 4'b0000, 32'h0,       32'h0,        32'h0,         0, 0, 1};

    // Reset state
    #1;
    chk("rst req", dmem_req_o, 1'b0);
    chk("rst valid", valid_o, 1'b0);
    chk("rst waddr", waddr_o, 5'd0);
    chk("rst we", we_o, 1'b0);
    chk("rst wdata", wdata_o, 32'd0);
    chk("rst flags", {adel_o, ades_o, buserr_o}, 3'b000);
    tick(); tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 19; i++) run_vec(vt[i], i);

    // LB with ack in third REQ cycle: three stall cycles
    drive(4'd1, 32'h0000_1001, 32'h0, 5'd17, 1'b1, 32'h0);
    #1 chk("lb3 stall0", stall_o, 1'b1);
    tick(); valid_i = 1'b0;
    chk("lb3 stall1", stall_o, 1'b1);
    tick();
    chk("lb3 stall2", stall_o, 1'b1);
    chk("lb3 req_held", dmem_req_o, 1'b1);
    tick();
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1180_3344;
    #1 chk("lb3 stall3", stall_o, 1'b0);
    tick(); dmem_ack_i = 1'b0;
    chk("lb3 valid", valid_o, 1'b1);
    chk("lb3 wdata", wdata_o, 32'hFFFF_FF80);
    tick();

    // Timeout: req held 15 cycles then bus error
    begin
      int n;
      n = 0;
      drive(4'd5, 32'h0000_3000, 32'h0, 5'd18, 1'b1, 32'h0);
      tick(); valid_i = 1'b0;
      while (dmem_req_o && n < 40) begin
        n++;
        tick();
      end
      chk("to req_cycles", n, 15);
      chk("to buserr", buserr_o, 1'b1);
      chk("to valid", valid_o, 1'b1);
      chk("to we", we_o, 1'b0);
      chk("to req", dmem_req_o, 1'b0);
      tick();
      chk("to buserr_pulse", buserr_o, 1'b0);
      chk("to idle_stall", stall_o, 1'b0);
    end

    // Ack on the timeout cycle wins
    drive(4'd5, 32'h0000_3000, 32'h0, 5'd2, 1'b1, 32'h0);
    tick(); valid_i = 1'b0;
    repeat (14) tick();
    chk("tw req", dmem_req_o, 1'b1);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1357_9BDF;
    tick(); dmem_ack_i = 1'b0;
    chk("tw buserr", buserr_o, 1'b0);
    chk("tw valid", valid_o, 1'b1);
    chk("tw we", we_o, 1'b1);
    chk("tw wdata", wdata_o, 32'h1357_9BDF);
    tick();

    // Back-to-back LW then SW, ack in first REQ cycle each
    drive(4'd5, 32'h0000_0010, 32'h0, 5'd20, 1'b1, 32'h0);
    tick();
    chk("b2b lw_req", dmem_req_o, 1'b1);
    dmem_ack_i = 1'b1; dmem_rdata_i = 32'hA5A5_0F0F;
    drive(4'd8, 32'h0000_0014, 32'hDEAD_BEEF, 5'd21, 1'b0, 32'h0000_0042);
    tick(); dmem_ack_i = 1'b0;
    chk("b2b lw_valid", valid_o, 1'b1);
    chk("b2b lw_wdata", wdata_o, 32'hA5A5_0F0F);
    chk("b2b sw_stall", stall_o, 1'b1);
    tick(); valid_i = 1'b0;
    chk("b2b sw_req", dmem_req_o, 1'b1);
    chk("b2b sw_dwe", dmem_we_o, 1'b1);
    chk("b2b sw_dwdata", dmem_wdata_o, 32'hDEAD_BEEF);
    dmem_ack_i = 1'b1;
    tick(); dmem_ack_i = 1'b0;
    chk("b2b sw_valid", valid_o, 1'b1);
    chk("b2b sw_waddr", waddr_o, 5'd21);
    chk("b2b sw_wdata", wdata_o, 32'h0000_0042);
    tick();

    // Asynchronous reset in the middle of REQ
    drive(4'd5, 32'h0000_0020, 32'h0, 5'd22, 1'b1, 32'h0);
    tick(); valid_i = 1'b0;
    chk("arst pre_req", dmem_req_o, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst req", dmem_req_o, 1'b0);
    chk("arst valid", valid_o, 1'b0);
    chk("arst waddr", waddr_o, 5'd0);
    chk("arst stall", stall_o, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("arst post_req", dmem_req_o, 1'b0);
    chk("arst post_valid", valid_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
